// File: rtl/acs_unit_if.sv
// Bus between bmu, the ACS stage and the downstream traceback: seed metrics and
// received pairs in, state metrics, survivor decisions and frame status out.
interface acs_unit_if #(
  parameter int PM_W  = 6,
  parameter int CNT_W = 8
);
  logic [3:0]       branch_metric_000;
  logic [3:0]       branch_metric_001;
  logic [3:0]       branch_metric_010;
  logic [3:0]       branch_metric_011;
  logic [3:0]       branch_metric_100;
  logic [3:0]       branch_metric_101;
  logic [3:0]       branch_metric_110;
  logic [3:0]       branch_metric_111;
  logic             init_valid;
  logic [1:0]       bit_pair_input;
  logic             pair_valid;
  logic [PM_W-1:0]  pm_0;
  logic [PM_W-1:0]  pm_1;
  logic [PM_W-1:0]  pm_2;
  logic [PM_W-1:0]  pm_3;
  logic [3:0]       decision;
  logic             decision_valid;
  logic [1:0]       best_state;
  logic [CNT_W-1:0] stage_cnt;
  logic             busy;
  logic             frame_done;
  logic             fsm_state;

  modport master (
    output branch_metric_000, branch_metric_001, branch_metric_010, branch_metric_011,
           branch_metric_100, branch_metric_101, branch_metric_110, branch_metric_111,
           init_valid, bit_pair_input, pair_valid,
    input  pm_0, pm_1, pm_2, pm_3, decision, decision_valid, best_state,
           stage_cnt, busy, frame_done, fsm_state
  );

  modport slave (
    input  branch_metric_000, branch_metric_001, branch_metric_010, branch_metric_011,
           branch_metric_100, branch_metric_101, branch_metric_110, branch_metric_111,
           init_valid, bit_pair_input, pair_valid,
    output pm_0, pm_1, pm_2, pm_3, decision, decision_valid, best_state,
           stage_cnt, busy, frame_done, fsm_state
  );
endinterface

// File: rtl/acs_unit.sv
// Add-compare-select stage of the K=3 (7,5) hard-decision Viterbi decoder:
// seeds four state metrics from bmu, then runs one ACS step per received pair.
module acs_unit #(
  parameter int PM_W      = 6,
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 8
) (
  input  logic     clk,
  input  logic     rst,
  acs_unit_if.slave bus
);
  // Handshake: init_valid and pair_valid are qualifiers without backpressure. Data
  // is consumed on any rising edge where the valid is high and the FSM accepts it
  // (init_valid only in IDLE, pair_valid only in RUN); results appear one cycle
  // later, flagged by decision_valid.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [PM_W:0]    HALF = (PM_W+1)'(2 ** (PM_W - 1));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);

  state_t                state_q, state_d;
  logic [3:0][PM_W-1:0]  pm_q, pm_d, seed_pm, acs_pm;
  logic [3:0]            dec_q, dec_d, seed_dec, acs_dec;
  logic [3:0][PM_W:0]    cand0, cand1, sel_val;
  logic                  all_high;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dv_q, dv_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]            best_q, best_d;
  logic [7:0][3:0]       bm;

  assign bm = {bus.branch_metric_111, bus.branch_metric_110, bus.branch_metric_101,
               bus.branch_metric_100, bus.branch_metric_011, bus.branch_metric_010,
               bus.branch_metric_001, bus.branch_metric_000};

  function automatic logic [1:0] min_idx(input logic [3:0][PM_W-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 1; i < 4; i++) if (v[i] < v[idx]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] x);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Seed: state {y,z} keeps the better of the two 3-stage paths 0yz and 1yz.
  always_comb begin : seed_calc
    for (int s = 0; s < 4; s++) begin
      seed_dec[s] = bm[s+4] < bm[s];
      seed_pm[s]  = PM_W'(seed_dec[s] ? bm[s+4] : bm[s]);
    end
  end

  // New state {b,u} is reached from {0,b} and {1,b}; the a=1 branch emits the
  // complement of the a=0 branch's pair, hence the inverted expected bits.
  always_comb begin : acs_calc
    logic [1:0] st;
    st       = 2'd0;
    all_high = 1'b1;
    for (int ns = 0; ns < 4; ns++) begin
      st          = 2'(ns);
      cand0[ns]   = {1'b0, pm_q[{1'b0, st[1]}]} +
                    (PM_W+1)'(hamming({st[0] ^ st[1], st[0]} ^ bus.bit_pair_input));
      cand1[ns]   = {1'b0, pm_q[{1'b1, st[1]}]} +
                    (PM_W+1)'(hamming({~(st[0] ^ st[1]), ~st[0]} ^ bus.bit_pair_input));
      acs_dec[ns] = cand1[ns] < cand0[ns];
      sel_val[ns] = acs_dec[ns] ? cand1[ns] : cand0[ns];
      if (sel_val[ns] < HALF) all_high = 1'b0;
    end
    for (int ns = 0; ns < 4; ns++) begin
      acs_pm[ns] = PM_W'(sel_val[ns] - (all_high ? HALF : '0));
    end
  end

  always_comb begin : next_calc
    state_d = state_q;
    pm_d    = pm_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.init_valid) begin
          pm_d    = seed_pm;
          dec_d   = seed_dec;
          best_d  = min_idx(seed_pm);
          cnt_d   = '0;
          dv_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.pair_valid) begin
          pm_d   = acs_pm;
          dec_d  = acs_dec;
          best_d = min_idx(acs_pm);
          cnt_d  = cnt_q + CNT_W'(1);
          dv_d   = 1'b1;
          if (cnt_q + CNT_W'(1) == LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pm_q    <= '0;
      dec_q   <= '0;
      cnt_q   <= '0;
      best_q  <= '0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pm_q    <= pm_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
    end
  end

  assign bus.pm_0           = pm_q[0];
  assign bus.pm_1           = pm_q[1];
  assign bus.pm_2           = pm_q[2];
  assign bus.pm_3           = pm_q[3];
  assign bus.decision       = dec_q;
  assign bus.decision_valid = dv_q;
  assign bus.best_state     = best_q;
  assign bus.stage_cnt      = cnt_q;
  assign bus.busy           = busy_q;
  assign bus.frame_done     = done_q;
  assign bus.fsm_state      = (state_q == RUN);
endmodule

// File: doc/acs_unit.md
Name: acs_unit

Overview:
- Add-compare-select stage of the K=3, rate-1/2 (7,5) hard-decision Viterbi decoder.
- Sits directly downstream of bmu. It takes bmu's eight 3-stage cumulative path metrics once, to seed four state metrics, then runs one ACS step per received bit pair.
- Emits per-stage survivor decision bits, the normalised path metrics and the best state. A traceback block downstream consumes these.

Parameters:
- PM_W, 6, path metric register width; must be >= 5.
- FRAME_LEN, 32, number of steady-state ACS stages per frame after seeding; must be <= 2^CNT_W-1.
- CNT_W, 8, stage counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- branch_metric_000 .. branch_metric_111  input  4 each (8 ports)  bmu cumulative metrics; path index = {u1,u2,u3}, u3 newest
- init_valid  input  1  bmu valid_out; seeds the trellis
- bit_pair_input  input  2  received pair; [1] = g1 (111) bit, [0] = g2 (101) bit
- pair_valid  input  1  bit_pair_input valid this cycle
- pm_0 .. pm_3  output  PM_W each  state metrics; state index = {u(n-1), u(n)}
- decision  output  4  bit s = survivor predecessor MSB for state s
- decision_valid  output  1  decision/pm_*/best_state updated this cycle
- best_state  output  2  index of minimum pm; lowest index wins ties
- stage_cnt  output  CNT_W  ACS stages completed in current frame
- busy  output  1  high in RUN
- frame_done  output  1  one-cycle pulse after final stage

Behaviour:
- Reset (rst==0 at a clk edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - This applies from any state, including mid-RUN; in-flight data is discarded.
- FSM states: IDLE, RUN.
- IDLE:
  - pair_valid is ignored.
  - On init_valid==1, perform the seed step and go to RUN.
- Seed step, for each state s = {y,z}:
  - pm_s = min(bm_0yz, bm_1yz), zero-extended to PM_W.
  - decision[s] = 1 only if bm_1yz < bm_0yz strictly; a tie gives 0.
  - stage_cnt <= 0, decision_valid <= 1, busy <= 1.
- RUN:
  - init_valid is ignored (bmu holds valid_out high).
  - On pair_valid==1, one ACS step. New state {b,u} has predecessors {0,b} and {1,b}.
  - Expected pair from {a,b} with input u: {u^b^a, u^a}.
  - Branch metric bm = Hamming distance (0..2) between the expected pair and bit_pair_input.
  - cand_a = pm_{a,b} + bm, computed at PM_W+1 bits.
  - Select the smaller candidate; a tie selects a=0. decision[{b,u}] = selected a.
- Normalisation (same cycle as the step):
  - If all four selected values are >= 2^(PM_W-1), subtract 2^(PM_W-1) from all four before registering.
  - Stored metrics never overflow PM_W bits.
- Stage bookkeeping:
  - Each step increments stage_cnt and asserts decision_valid for one cycle.
  - best_state is computed from the stored (post-normalisation) values.
- pair_valid==0 in RUN: hold pm_*, decision, best_state and stage_cnt; decision_valid <= 0.
- End of frame: the step that makes stage_cnt == FRAME_LEN also sets frame_done <= 1 for one cycle, busy <= 0 and returns the FSM to IDLE. pm_* and stage_cnt hold until the next seed.
- Latency: all outputs are registered, one cycle after the accepting edge.
- Simultaneous init_valid and pair_valid:
  - In IDLE, the seed wins and the pair is dropped.
  - In RUN, the pair is processed.

Test Plan:
- Seed from received 00,00,00: bm (000..111) = 0,2,3,3,5,3,4,4 with init_valid -> pm = 0,2,3,3; decision=0000; best_state=0; stage_cnt=0; busy=1.
- Seed ties: bm_000=bm_100=2 and bm_011=4, bm_111=1, others 7 -> pm_0=2 with decision[0]=0; pm_3=1 with decision[3]=1; best_state=3.
- ACS step:
  - Setup: seed of scenario 1, then pair 00 with pair_valid.
  - Response: pm = 0,2,3,3; decision=0000; stage_cnt=1; decision_valid high for exactly 1 cycle.
  - Check: a pair_valid gap holds all values with decision_valid=0.
- Normalisation at PM_W=5:
  - Drive a state where the selected values are 17,16,18,16 -> stored pm = 1,0,2,0.
  - Stream 64 alternating 01/10 pairs -> pm_* match the golden model modulo normalisation and never wrap.
- Frame end at FRAME_LEN=4:
  - Seed plus 4 pairs -> frame_done pulses one cycle after the 4th pair; busy drops; stage_cnt=4.
  - A 5th pair is ignored; a new init_valid reseeds and sets stage_cnt=0.
- Reset: rst=0 mid-RUN at stage 2 -> next edge all outputs 0 and FSM in IDLE; pair_valid is ignored until init_valid.
